// File: rtl/la_pkg.sv
`default_nettype none
// ============================================================================
// Module   : la_pkg
// Purpose  : Shared types and helpers for the logic-analyzer capture core.
//            Holds the FSM state encoding and modular address arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
package la_pkg;

  localparam int LA_ST_W = 3;

  typedef enum logic [LA_ST_W-1:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } la_state_e;

  // (base - sub + add) mod depth; depth must be a power of two.
  function automatic int unsigned la_addr_wrap(input int unsigned base,
                                               input int unsigned sub,
                                               input int unsigned add,
                                               input int unsigned depth);
    return (base - sub + add) & (depth - 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/la_trig_match.sv
`default_nettype none
// ============================================================================
// Module   : la_trig_match
// Purpose  : Combinational multi-bit trigger comparator.
//            Per masked bit: level mode requires i_trig == i_value; edge mode
//            requires a transition from i_prev to i_trig ending at i_value
//            (1 = rising, 0 = falling). Result is the AND over masked bits;
//            an all-zero mask matches unconditionally.
// Ports    : i_trig  - current trigger inputs
//            i_mask  - 1 = bit participates
//            i_value - required level / edge direction
//            i_edge  - 0 = level, 1 = edge
//            i_prev  - registered trigger inputs from the previous cycle
//            o_match - trigger condition satisfied this cycle
// Revision : 1.0 - initial release
// ============================================================================
module la_trig_match #(
  parameter int TRIG_W = 4
) (
  input  logic [TRIG_W-1:0] i_trig,
  input  logic [TRIG_W-1:0] i_mask,
  input  logic [TRIG_W-1:0] i_value,
  input  logic [TRIG_W-1:0] i_edge,
  input  logic [TRIG_W-1:0] i_prev,
  output logic              o_match
);

  logic [TRIG_W-1:0] w_bit_ok;

  for (genvar i = 0; i < TRIG_W; i++) begin : g_bit
    // An edge is the required level now plus a different level last cycle.
    assign w_bit_ok[i] = i_edge[i]
                       ? ((i_trig[i] == i_value[i]) && (i_prev[i] != i_trig[i]))
                       : (i_trig[i] == i_value[i]);
  end

  assign o_match = &(~i_mask | w_bit_ok);

endmodule
`default_nettype wire

// File: rtl/la_capture_core.sv
`default_nettype none
// ============================================================================
// Module   : la_capture_core
// Purpose  : Parametrised logic-analyzer capture core. Samples DATA_W probe
//            bits per clock into a circular buffer, with masked level/edge
//            trigger and programmable pre-trigger depth. Samples are read back
//            in logical order (0 = oldest) once the capture is complete.
// Option   : LA_TRIG_COUNT_EN - adds trig_count_i / match_cnt_o; the trigger
//            fires on the (trig_count_i+1)-th match.
// Ports    : clk_i, rst_n_i (async, active low)
//            data_i, trig_i                       - probe and trigger nets
//            arm_i, abort_i                       - capture control pulses
//            trig_mask_i/value_i/edge_i, pretrig_i - config, latched at arm
//            state_o, triggered_o, done_o, trig_addr_o - status
//            rd_en_i, rd_addr_i, rd_data_o, rd_valid_o - sample readout
// Revision : 1.0 - initial release
// ============================================================================
module la_capture_core
  import la_pkg::*;
#(
  parameter int DATA_W = 21,
  parameter int DEPTH  = 1024,
  parameter int TRIG_W = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic [TRIG_W-1:0]        trig_i,
  input  logic                     arm_i,
  input  logic                     abort_i,
  input  logic [TRIG_W-1:0]        trig_mask_i,
  input  logic [TRIG_W-1:0]        trig_value_i,
  input  logic [TRIG_W-1:0]        trig_edge_i,
  input  logic [$clog2(DEPTH)-1:0] pretrig_i,
  output logic [LA_ST_W-1:0]       state_o,
  output logic                     triggered_o,
  output logic                     done_o,
  output logic [$clog2(DEPTH)-1:0] trig_addr_o,
`ifdef LA_TRIG_COUNT_EN
  input  logic [15:0]              trig_count_i,
  output logic [15:0]              match_cnt_o,
`endif
  input  logic                     rd_en_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     rd_valid_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] c_ADDR_MAX = AW'(DEPTH - 1);
  localparam logic [AW-1:0] c_ONE      = AW'(1);

  la_state_e         r_state;
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_cnt;
  logic [AW-1:0]     r_pretrig;
  logic [AW-1:0]     r_trig_addr;
  logic [TRIG_W-1:0] r_mask;
  logic [TRIG_W-1:0] r_value;
  logic [TRIG_W-1:0] r_edge;
  logic [TRIG_W-1:0] r_prev_trig;
  logic              r_triggered;
  logic              r_done;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_match;
  logic              w_fire;
  logic              w_wr_en;
  logic              w_rd_hit;
  logic [AW-1:0]     w_post;
  logic [AW-1:0]     w_rd_addr;
  la_state_e         w_arm_state;

  la_trig_match #(
    .TRIG_W (TRIG_W)
  ) u_trig_match (
    .i_trig  (trig_i),
    .i_mask  (r_mask),
    .i_value (r_value),
    .i_edge  (r_edge),
    .i_prev  (r_prev_trig),
    .o_match (w_match)
  );

`ifdef LA_TRIG_COUNT_EN
  logic [15:0] r_trig_count;
  logic [15:0] r_match_cnt;

  // Fire only once trig_count earlier matches have been seen.
  assign w_fire      = w_match && (r_match_cnt == r_trig_count);
  assign match_cnt_o = r_match_cnt;
`else
  assign w_fire = w_match;
`endif

  // Post-trigger samples fill the rest of the buffer after the trigger sample.
  assign w_post      = c_ADDR_MAX - r_pretrig;
  assign w_wr_en     = (r_state == ST_PRE) || (r_state == ST_WAIT) || (r_state == ST_POST);
  assign w_rd_hit    = rd_en_i && (r_state == ST_DONE);
  assign w_arm_state = (pretrig_i == '0) ? ST_WAIT : ST_PRE;
  assign w_rd_addr   = AW'(la_addr_wrap(32'(r_trig_addr), 32'(r_pretrig),
                                        32'(rd_addr_i), DEPTH));

  // Sample buffer write port; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      r_mem[r_wptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= ST_IDLE;
      r_wptr      <= '0;
      r_cnt       <= '0;
      r_pretrig   <= '0;
      r_trig_addr <= '0;
      r_mask      <= '0;
      r_value     <= '0;
      r_edge      <= '0;
      r_prev_trig <= '0;
      r_triggered <= 1'b0;
      r_done      <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
`ifdef LA_TRIG_COUNT_EN
      r_trig_count <= '0;
      r_match_cnt  <= '0;
`endif
    end else begin
      r_prev_trig <= trig_i;
      r_rd_valid  <= w_rd_hit;
      // Read data holds its previous value when no read is accepted.
      if (w_rd_hit) begin
        r_rd_data <= r_mem[w_rd_addr];
      end
      if (w_wr_en) begin
        r_wptr <= r_wptr + c_ONE;
      end

      if (abort_i) begin
        r_state     <= ST_IDLE;
        r_cnt       <= '0;
        r_triggered <= 1'b0;
        r_done      <= 1'b0;
`ifdef LA_TRIG_COUNT_EN
        r_match_cnt <= '0;
`endif
      end else begin
        case (r_state)
          ST_IDLE, ST_DONE: begin
            if (arm_i) begin
              r_mask      <= trig_mask_i;
              r_value     <= trig_value_i;
              r_edge      <= trig_edge_i;
              // AW bits already bound the depth to DEPTH-1.
              r_pretrig   <= pretrig_i;
              r_state     <= w_arm_state;
              r_cnt       <= '0;
              r_triggered <= 1'b0;
              r_done      <= 1'b0;
`ifdef LA_TRIG_COUNT_EN
              r_trig_count <= trig_count_i;
              r_match_cnt  <= '0;
`endif
            end
          end
          ST_PRE: begin
            if (r_cnt == r_pretrig - c_ONE) begin
              r_state <= ST_WAIT;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + c_ONE;
            end
          end
          ST_WAIT: begin
`ifdef LA_TRIG_COUNT_EN
            if (w_match && (r_match_cnt != 16'hFFFF)) begin
              r_match_cnt <= r_match_cnt + 16'd1;
            end
`endif
            if (w_fire) begin
              r_trig_addr <= r_wptr;
              r_triggered <= 1'b1;
              r_cnt       <= '0;
              if (w_post == '0) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= ST_POST;
              end
            end
          end
          ST_POST: begin
            if (r_cnt == w_post - c_ONE) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + c_ONE;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign state_o     = r_state;
  assign triggered_o = r_triggered;
  assign done_o      = r_done;
  assign trig_addr_o = r_trig_addr;
  assign rd_data_o   = r_rd_data;
  assign rd_valid_o  = r_rd_valid;

endmodule
`default_nettype wire

// File: tb/tb_la_capture_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_la_capture_core
// Purpose  : Directed self-checking bench for la_capture_core with DEPTH=16,
//            DATA_W=8, TRIG_W=4 and a free-running counter on data_i.
//            Exercises LA_TRIG_COUNT_EN when that macro is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_la_capture_core;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int TRIG_W = 4;
  localparam int AW     = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] data;
  logic [TRIG_W-1:0] trig;
  logic              arm;
  logic              abort;
  logic [TRIG_W-1:0] mask;
  logic [TRIG_W-1:0] value;
  logic [TRIG_W-1:0] edge_sel;
  logic [AW-1:0]     pretrig;
  logic [2:0]        state;
  logic              triggered;
  logic              done;
  logic [AW-1:0]     trig_addr;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
`ifdef LA_TRIG_COUNT_EN
  logic [15:0]       trig_count;
  logic [15:0]       match_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] d_ref;

  always #5 clk = ~clk;

  la_capture_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .TRIG_W (TRIG_W)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .data_i       (data),
    .trig_i       (trig),
    .arm_i        (arm),
    .abort_i      (abort),
    .trig_mask_i  (mask),
    .trig_value_i (value),
    .trig_edge_i  (edge_sel),
    .pretrig_i    (pretrig),
    .state_o      (state),
    .triggered_o  (triggered),
    .done_o       (done),
    .trig_addr_o  (trig_addr),
`ifdef LA_TRIG_COUNT_EN
    .trig_count_i (trig_count),
    .match_cnt_o  (match_cnt),
`endif
    .rd_en_i      (rd_en),
    .rd_addr_i    (rd_addr),
    .rd_data_o    (rd_data),
    .rd_valid_o   (rd_valid)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: outputs are sampled 1 ns after the edge, then data advances.
  task automatic tick();
    @(posedge clk);
    #1;
    data = data + 8'd1;
  endtask

  task automatic arm_cfg(input logic [3:0] m, input logic [3:0] v,
                         input logic [3:0] e, input logic [3:0] p);
    mask = m; value = v; edge_sel = e; pretrig = p;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
    rd_en = 1'b1;
    rd_addr = a;
    tick();
    rd_en = 1'b0;
    check_eq({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check_eq({tag, "_data"}, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    rst_n = 1'b0; data = '0; trig = '0; arm = 1'b0; abort = 1'b0;
    mask = '0; value = '0; edge_sel = '0; pretrig = '0;
    rd_en = 1'b0; rd_addr = '0;
`ifdef LA_TRIG_COUNT_EN
    trig_count = '0;
`endif
    #12;
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_trig", 32'(triggered), 32'd0);
    check_eq("rst_taddr", 32'(trig_addr), 32'd0);
    check_eq("rst_rdv", 32'(rd_valid), 32'd0);
    check_eq("rst_rdd", 32'(rd_data), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Level trigger on bit 0, pretrig 4, trigger at sample 20.
    while (data != 8'd10) tick();
    arm_cfg(4'b0001, 4'b0001, 4'b0000, 4'd4);
    check_eq("t1_pre", 32'(state), 32'd1);
    while (data != 8'd20) tick();
    trig = 4'b0001;
    tick();
    check_eq("t1_trig", 32'(triggered), 32'd1);
    check_eq("t1_post", 32'(state), 32'd3);
    check_eq("t1_taddr", 32'(trig_addr), 32'd9);
    repeat (10) tick();
    check_eq("t1_notdone", 32'(done), 32'd0);
    tick();
    check_eq("t1_done", 32'(done), 32'd1);
    check_eq("t1_stdone", 32'(state), 32'd4);
    for (int i = 0; i < 16; i++) read_chk("t1_rd", 4'(i), 8'(16 + i));
    tick();
    check_eq("t1_rdv_off", 32'(rd_valid), 32'd0);
    check_eq("t1_rd_hold", 32'(rd_data), 32'd31);

    // Falling-edge trigger on bit 1.
    trig = 4'b0000;
    arm_cfg(4'b0010, 4'b0000, 4'b0010, 4'd0);
    check_eq("t2_wait", 32'(state), 32'd2);
    check_eq("t2_done_clr", 32'(done), 32'd0);
    check_eq("t2_trig_clr", 32'(triggered), 32'd0);
    repeat (5) tick();
    check_eq("t2_low", 32'(triggered), 32'd0);
    trig = 4'b0010;
    tick();
    check_eq("t2_rise", 32'(triggered), 32'd0);
    trig = 4'b0000;
    d_ref = data;
    tick();
    check_eq("t2_fall", 32'(triggered), 32'd1);
    check_eq("t2_taddr", 32'(trig_addr), 32'd11);
    repeat (14) tick();
    check_eq("t2_notdone", 32'(done), 32'd0);
    tick();
    check_eq("t2_done", 32'(done), 32'd1);
    read_chk("t2_rd0", 4'd0, d_ref);
    read_chk("t2_rd15", 4'd15, d_ref + 8'd15);

    // Empty mask, no pre-trigger: fires on the sample after arm.
    arm_cfg(4'b0000, 4'b0000, 4'b0000, 4'd0);
    check_eq("t3_wait", 32'(state), 32'd2);
    d_ref = data;
    tick();
    check_eq("t3_trig", 32'(triggered), 32'd1);
    check_eq("t3_post", 32'(state), 32'd3);
    repeat (15) tick();
    check_eq("t3_done", 32'(done), 32'd1);
    read_chk("t3_rd0", 4'd0, d_ref);
    read_chk("t3_rd7", 4'd7, d_ref + 8'd7);
    read_chk("t3_rd15", 4'd15, d_ref + 8'd15);

    // Maximum pre-trigger: DONE on the trigger cycle itself.
    trig = 4'b0000;
    arm_cfg(4'b0001, 4'b0001, 4'b0000, 4'd15);
    check_eq("t4_pre", 32'(state), 32'd1);
    repeat (15) tick();
    check_eq("t4_wait", 32'(state), 32'd2);
    repeat (2) tick();
    trig = 4'b0001;
    d_ref = data;
    tick();
    check_eq("t4_done", 32'(done), 32'd1);
    check_eq("t4_stdone", 32'(state), 32'd4);
    read_chk("t4_rd15", 4'd15, d_ref);
    read_chk("t4_rd0", 4'd0, d_ref - 8'd15);

    // Abort in POST, abort beating arm, arm ignored in WAIT.
    trig = 4'b0000;
    arm_cfg(4'b0000, 4'b0000, 4'b0000, 4'd0);
    tick();
    check_eq("t5_post", 32'(state), 32'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("t5_abort_st", 32'(state), 32'd0);
    check_eq("t5_abort_done", 32'(done), 32'd0);
    check_eq("t5_abort_trig", 32'(triggered), 32'd0);
    arm = 1'b1; abort = 1'b1;
    tick();
    arm = 1'b0; abort = 1'b0;
    check_eq("t5_arm_abort", 32'(state), 32'd0);
    arm_cfg(4'b0001, 4'b0001, 4'b0000, 4'd0);
    check_eq("t5_wait", 32'(state), 32'd2);
    arm_cfg(4'b0000, 4'b0000, 4'b0000, 4'd4);
    check_eq("t5_rearm_st", 32'(state), 32'd2);
    check_eq("t5_rearm_trig", 32'(triggered), 32'd0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check_eq("t5_rdv_wait", 32'(rd_valid), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;

`ifdef LA_TRIG_COUNT_EN
    // Fire on the third match.
    trig = 4'b0000;
    trig_count = 16'd2;
    arm_cfg(4'b0001, 4'b0001, 4'b0000, 4'd0);
    check_eq("t6_cnt_clr", 32'(match_cnt), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      trig = 4'b0001;
      tick();
      trig = 4'b0000;
      check_eq("t6_cnt", 32'(match_cnt), 32'(k));
      check_eq("t6_trig", 32'(triggered), (k == 3) ? 32'd1 : 32'd0);
      if (k < 3) tick();
    end
    repeat (15) tick();
    check_eq("t6_done", 32'(done), 32'd1);
    check_eq("t6_cnt_done", 32'(match_cnt), 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/la_capture_core.md
Name: la_capture_core

Overview:
- Parametrised logic-analyzer capture core, successor to the fixed 21-bit single-trigger analyzer core.
- Samples DATA_W probe bits every clk_i cycle into a circular on-chip buffer.
- Multi-bit trigger with per-bit mask, level/edge mode and programmable pre-trigger depth.
- Sits between the probe nets and the JTAG control hub, which drives arm/config and reads back samples.

Parameters:
DATA_W, 21, probe data width in bits
DEPTH, 1024, sample buffer depth; power of two, >= 4
TRIG_W, 4, trigger input width in bits
AW, $clog2(DEPTH), address width; derived, not overridable

Ports:
clk_i  in  1  sample clock
rst_n_i  in  1  asynchronous active-low reset
data_i  in  DATA_W  probe samples
trig_i  in  TRIG_W  trigger inputs
arm_i  in  1  single-cycle pulse; start a capture
abort_i  in  1  single-cycle pulse; cancel the capture and return to IDLE
trig_mask_i  in  TRIG_W  1 = bit participates in the trigger
trig_value_i  in  TRIG_W  level mode: required level; edge mode: 1 = rising, 0 = falling
trig_edge_i  in  TRIG_W  per bit: 0 = level, 1 = edge
pretrig_i  in  AW  number of samples kept before the trigger
state_o  out  3  current FSM state encoding
triggered_o  out  1  trigger seen in the current capture
done_o  out  1  buffer holds a complete capture
trig_addr_o  out  AW  physical buffer address of the trigger sample
rd_en_i  in  1  read request
rd_addr_i  in  AW  logical address; 0 = oldest sample
rd_data_o  out  DATA_W  read data
rd_valid_o  out  1  rd_data_o is valid

Behaviour:
- Reset values: state IDLE; all outputs 0; write pointer 0; counters 0; trig_i history register 0.
- Config inputs (mask, value, edge, pretrig) are latched on the arm_i cycle and held stable for the whole capture.
- pretrig latched value is clamped to DEPTH-1.
- Trigger match: per masked bit, level mode requires trig_i==value. Edge mode compares against the registered previous trig_i.
- Match = AND over all masked bits. A mask of all zeros matches immediately.
- FSM states: IDLE(0), PRE(1), WAIT(2), POST(3), DONE(4).
- IDLE: no writes. arm_i -> PRE, or -> WAIT when pretrig==0. Pre-count is cleared on the transition.
- PRE: write data_i each cycle, pointer increments and wraps mod DEPTH. Move to WAIT once pretrig samples are written. Triggers are ignored in PRE.
- WAIT: write each cycle. On match, the sample of that cycle is the trigger sample: trig_addr_o <= current write pointer, triggered_o <= 1.
  - If post = DEPTH-1-pretrig equals 0, go to DONE; otherwise go to POST.
  - The buffer wraps freely while waiting.
- POST: write post further samples, then go to DONE.
- DONE: no writes. done_o=1. arm_i restarts: done_o and triggered_o cleared, -> PRE or WAIT.
- abort_i in any state -> IDLE, clears done_o and triggered_o. abort_i wins over a same-cycle arm_i.
- arm_i in PRE, WAIT or POST is ignored.
- Readout: physical address = (trig_addr - pretrig + rd_addr_i) mod DEPTH.
  - Synchronous RAM, 1-cycle latency.
  - rd_valid_o = registered (rd_en_i && state==DONE).
  - rd_data_o holds its last value when rd_valid_o=0.
- Async reset mid-capture: return to IDLE immediately. Buffer contents are undefined.

Optional Feature:
- Macro: LA_TRIG_COUNT_EN.
- Defined:
  - Adds input trig_count_i[15:0], latched at arm.
  - The trigger fires on the (trig_count_i+1)-th match in WAIT; a value of 0 behaves as without the feature.
  - Adds output match_cnt_o[15:0] (matches seen so far), reset at arm and abort.
- Undefined: ports absent; first match fires.

Decomposition:
- Package la_pkg:
  - la_state_e enum with the encodings above.
  - LA_ST_W=3.
  - Helper function for modular address arithmetic.
- Sub-module la_trig_match:
  - Inputs: trig_i, mask, value, edge, registered previous trig.
  - Output: 1-bit match, combinational.
- Buffer is inferred simple dual-port RAM inside la_capture_core.

Test Plan (DEPTH=16, DATA_W=8, TRIG_W=4, data_i = free-running counter):
- mask=0001, value=0001, level, pretrig=4; arm; trig_i[0] rises when data=20 -> done_o after 11 more cycles; logical reads 0..15 return 16..31 (trigger sample 20 at logical 4).
- Edge mode on bit 1, value=0 (falling); trig_i[1] held 0 from arm -> no trigger; drive 1 then 0 -> trigger on the falling cycle only.
- Mask=0000, pretrig=0 -> trigger on the arm+1 sample; 15 post samples; reads are contiguous.
- pretrig=15 -> DONE on the trigger cycle; trigger sample at logical address 15.
- abort_i during POST -> state_o=0, done_o=0. Same-cycle arm_i+abort_i -> stays IDLE. arm_i in WAIT -> no effect.
- LA_TRIG_COUNT_EN with trig_count_i=2 -> fires on the third match; match_cnt_o=3 at DONE.
